button_event_fsm: RTL and testbench



---
 rtl/button_pkg.sv | 14 +
 rtl/button_event_fsm_event_counter.sv | 38 +++
 rtl/button_event_fsm.sv | 138 +++++++++++++
 tb/tb_button_event_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and 100 MHz timing defaults for the button event FSM.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } btn_state_e;

    localparam int unsigned LONG_CYCLES_DEFAULT   = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT = 10_000_000;
    localparam int unsigned CNT_W_DEFAULT         = 27;

endpackage

// File: rtl/button_event_fsm_event_counter.sv
// CNT_W-bit up-counter with synchronous clear/enable and a combinational
// flag raised on the last count before the terminal value.
module event_counter
    import button_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == terminal - CNT_W'(1));

endmodule

// File: rtl/button_event_fsm.sv
// Turns the debounced button level into registered press/release/click/long
// events; auto-repeat in HELD is compiled in with BUTTON_AUTO_REPEAT_EN.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic holding,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES);

    btn_state_e state_q, state_d;

    logic press_q,   press_d;
    logic release_q, release_d;
    logic click_q,   click_d;
    logic long_q,    long_d;
    logic holding_q, holding_d;
    logic repeat_q,  repeat_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_terminal;

    assign cnt_terminal = (state_q == ST_HELD) ? REPEAT_T : LONG_T;

    event_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .terminal (cnt_terminal),
        .hit      (cnt_hit)
    );

    // Release is tested before the counter hit so it wins on a shared edge.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (debounced) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                cnt_en = 1'b1;
                if (!debounced) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (cnt_hit) begin
                    state_d = ST_HELD;
                    long_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            ST_HELD: begin
`ifdef BUTTON_AUTO_REPEAT_EN
                cnt_en = 1'b1;
                if (!debounced) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (cnt_hit) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
`else
                cnt_clr = 1'b1;
                if (!debounced) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        holding_d = (state_d == ST_HELD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            holding_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            holding_q <= holding_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign holding       = holding_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: directed and random hold lengths checked against
// a model built on the length of the current run of high samples.
module tb_button_event_fsm;

    localparam int LONG   = 8;
    localparam int REPEAT = 4;

    logic clk;
    logic reset;
    logic debounced;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic holding;
    logic repeat_pulse;

    int checks;
    int errors;
    int cycle;

    // Model state: consecutive high samples up to and including the last edge.
    int   age;
    logic exp_press, exp_release, exp_click, exp_long, exp_hold, exp_repeat;

    button_event_fsm #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .holding       (holding),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cycle, observed, expected);
        end
    endtask

    task automatic model_clear();
        age         = 0;
        exp_press   = 1'b0;
        exp_release = 1'b0;
        exp_click   = 1'b0;
        exp_long    = 1'b0;
        exp_hold    = 1'b0;
        exp_repeat  = 1'b0;
    endtask

    task automatic model_edge(input logic d);
        int prev;
        if (!reset) begin
            model_clear();
            return;
        end
        prev        = age;
        age         = d ? age + 1 : 0;
        exp_press   = d && (age == 1);
        exp_release = !d && (prev > 0);
        exp_click   = exp_release && (prev <= LONG);
        exp_long    = d && (age == LONG + 1);
        exp_hold    = d && (age >= LONG + 1);
`ifdef BUTTON_AUTO_REPEAT_EN
        exp_repeat  = d && (age > LONG + 1) && (((age - LONG - 1) % REPEAT) == 0);
`else
        exp_repeat  = 1'b0;
`endif
    endtask

    task automatic check_outputs();
        check("press",   press_pulse,   exp_press);
        check("release", release_pulse, exp_release);
        check("click",   click_pulse,   exp_click);
        check("long",    long_pulse,    exp_long);
        check("holding", holding,       exp_hold);
        check("repeat",  repeat_pulse,  exp_repeat);
    endtask

    // Called at a negedge: drive, wait for the active edge, predict, sample.
    task automatic step(input logic d);
        debounced = d;
        @(posedge clk);
        cycle++;
        model_edge(d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input logic d, input int n);
        for (int i = 0; i < n; i++) step(d);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        reset     = 1'b0;
        debounced = 1'b0;
        model_clear();

        @(negedge clk);
        run(1'b0, 2);
        reset = 1'b1;
        run(1'b0, 2);

        // short press
        run(1'b1, 5);
        run(1'b0, 3);
        // long hold with three repeats
        run(1'b1, 22);
        run(1'b0, 3);
        // release on the threshold edge, then one cycle past it
        run(1'b1, LONG);
        run(1'b0, 2);
        run(1'b1, LONG + 1);
        run(1'b0, 2);
        // back-to-back short presses
        run(1'b1, 3);
        run(1'b0, 1);
        run(1'b1, 3);
        run(1'b0, 3);

        // asynchronous reset while holding
        run(1'b1, 12);
        #2 reset = 1'b0;
        #1 model_clear();
        check_outputs();
        run(1'b1, 2);
        reset = 1'b1;
        run(1'b1, 3);
        run(1'b0, 2);

        // random hold/gap lengths with occasional mid-run resets
        for (int seg = 0; seg < 60; seg++) begin
            run(1'b1, int'($urandom_range(1, 2 * LONG + 3 * REPEAT)));
            if ($urandom_range(0, 9) == 0) begin
                #3 reset = 1'b0;
                #1 model_clear();
                check_outputs();
                run(1'($urandom_range(0, 1)), 1);
                reset = 1'b1;
            end
            run(1'b0, int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
